multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Sequencing FSM for the multi-cycle RISC-V core: it steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It emits one-cycle write strobes for the PC, IR, MDR, register file and data RAM, and handshakes with instruction and data memories that may insert wait states. Per-instruction field decode (alu_op, sext_op, npc_op, rf_wsel) stays in the combinational decoder. This block only decides *when* each datapath register is written.

## Interface
- `IMEM_WAIT_MAX`, default 15: max imem wait cycles before `fault` (4-bit compare).
- `cpu_clk` in 1: clock; all state changes on its rising edge.
- `cpu_rst` in 1: synchronous, active-high reset.
- `opcode` in 7: IR[6:0], valid from DECODE onward.
- `branch_taken` in 1: ALU branch compare result, sampled in EXEC.
- `imem_ready` in 1: instruction word valid this cycle.
- `dmem_ready` in 1: data access completes this cycle.
- `imem_req` out 1: instruction fetch request.
- `dmem_req` out 1: data memory request.
- `ram_we` out 1: data write qualifier; only meaningful with `dmem_req`.
- `ir_we` out 1: latch instruction register.
- `mdr_we` out 1: latch load data.
- `rf_we` out 1: register file write.
- `pc_we` out 1: PC update.
- `pc_take` out 1: branch target select, valid with `pc_we`.
- `instr_done` out 1: one-cycle retire pulse.
- `state` out 3: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- `fault` out 1: sticky; set on illegal opcode or imem timeout.
- `cycle_cnt` out 32: cycle counter.
- `instret_cnt` out 32: retired-instruction counter.

## Operation
- Legal opcodes:
  - R = 0110011
  - I = 0010011
  - LOAD = 0000011
  - S = 0100011
  - B = 1100011
  - LUI = 0110111
  - JAL = 1101111
  - JALR = 1100111
- Any other opcode is illegal.
- FETCH:
  - `imem_req` = 1 and is held while waiting.
  - On `imem_ready`: `ir_we` = 1, next state DECODE.
  - Otherwise increment the 4-bit wait counter. When the counter reaches `IMEM_WAIT_MAX` with ready still low: set `fault`, next state HALT.
- DECODE:
  - Illegal opcode: set `fault`, next state HALT.
  - Otherwise next state EXEC.
- EXEC:
  - B: `pc_we` = 1, `pc_take` = `branch_taken`, `instr_done` = 1, next state FETCH.
  - LOAD or S: next state MEM.
  - Other legal opcodes: next state WB.
- MEM:
  - `dmem_req` = 1 and is held while waiting.
  - `ram_we` = 1 if S.
  - On `dmem_ready` with S: `pc_we` = 1, `instr_done` = 1, next state FETCH.
  - On `dmem_ready` with LOAD: `mdr_we` = 1, next state WB.
  - No timeout in MEM.
- WB: `rf_we` = 1, `pc_we` = 1, `instr_done` = 1, next state FETCH.
- HALT: all strobes and requests are 0. Exit only by reset.
- Output decode: strobes are combinational from the registered state plus inputs. Ready inputs are ignored in states that do not request.
- `pc_we` occurs exactly once per retired instruction, and `instr_done` == `pc_we` in every cycle.

## Timing
- Reset behaviour:
  - While `cpu_rst` = 1, all strobes and requests are forced to 0.
  - On the next edge: `state` = FETCH, `fault` = 0, wait counter = 0, both counters = 0.
  - Reset mid-instruction, including a MEM wait, abandons the instruction with no PC or RF write.
- Latency with zero wait (ready high in the first request cycle):
  - B: 3 cycles.
  - R, I, LUI, JAL, JALR, S: 4 cycles.
  - LOAD: 5 cycles.
  - Each wait cycle adds 1.
- `ir_we` and `imem_ready` are in the same cycle. The IR is valid in DECODE.
- The wait counter clears on leaving FETCH.
- `ram_we` is never high without `dmem_req`.

## Configuration
- `MC_PERF_CNT_EN` defined:
  - `cycle_cnt` increments every non-reset cycle except in HALT.
  - `instret_cnt` increments on `instr_done`.
  - Both are 32-bit and wrap from 0xFFFFFFFF to 0.
- `MC_PERF_CNT_EN` undefined: the ports remain and are tied to 0. No counter flops are built.

## Test plan
- Zero-wait memories, R then B (taken) then B (not taken):
  - R sees states 0,1,2,4 and `rf_we`+`pc_we` in cycle 4.
  - Each B retires in cycle 3 with `pc_take` = 1, then 0.
  - `instret_cnt` = 3.
- LOAD with `dmem_ready` delayed 2 cycles:
  - `dmem_req` is high for 3 cycles and `ram_we` = 0.
  - `mdr_we` fires in the third MEM cycle.
  - Total latency 7 cycles.
- S with zero wait: `ram_we` = 1 in MEM, `pc_we` in the same cycle, `rf_we` never asserted. 4 cycles.
- Illegal opcode 0000000 in DECODE: `fault` = 1, `state` = 5, no further strobes over 20 cycles. `cycle_cnt` is frozen.
- `imem_ready` held low: after 15 FETCH cycles, `fault` = 1 and HALT. Asserting `cpu_rst` for 1 cycle returns to FETCH with `fault` = 0.
- Reset asserted in the second MEM wait cycle of a store: `ram_we`/`dmem_req` are 0 during the reset cycle, `pc_we` never fires, and FETCH follows.
- With `MC_PERF_CNT_EN` defined, `cycle_cnt` preset near 0xFFFFFFFF by force: the count wraps to 0.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// Datapath/memory handshake bundle for the multi-cycle sequencer.
// master = the sequencer, slave = datapath and memories that respond to it.
interface multicycle_ctrl_if;
    logic [6:0]  opcode;
    logic        branch_taken;
    logic        imem_ready;
    logic        dmem_ready;
    logic        imem_req;
    logic        dmem_req;
    logic        ram_we;
    logic        ir_we;
    logic        mdr_we;
    logic        rf_we;
    logic        pc_we;
    logic        pc_take;
    logic        instr_done;
    logic [2:0]  state;
    logic        fault;
    logic [31:0] cycle_cnt;
    logic [31:0] instret_cnt;

    modport master (
        input  opcode, branch_taken, imem_ready, dmem_ready,
        output imem_req, dmem_req, ram_we, ir_we, mdr_we, rf_we, pc_we,
               pc_take, instr_done, state, fault, cycle_cnt, instret_cnt
    );

    modport slave (
        output opcode, branch_taken, imem_ready, dmem_ready,
        input  imem_req, dmem_req, ram_we, ir_we, mdr_we, rf_we, pc_we,
               pc_take, instr_done, state, fault, cycle_cnt, instret_cnt
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer deciding when each datapath register is written.
// Define MC_PERF_CNT_EN to build the cycle and retired-instruction counters.
module multicycle_ctrl #(
    parameter int IMEM_WAIT_MAX = 15
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [3:0] WAIT_MAX = 4'(IMEM_WAIT_MAX);

    state_e     state_q, state_d;
    logic       fault_q, fault_d;
    logic [3:0] wait_q, wait_d;
    logic [3:0] wait_inc;

    logic op_legal, op_branch, op_load, op_store;
    logic imem_req, dmem_req, ram_we, ir_we, mdr_we, rf_we, pc_we, pc_take, instr_done;

    always_comb begin
        op_branch = (bus.opcode == OP_B);
        op_load   = (bus.opcode == OP_LOAD);
        op_store  = (bus.opcode == OP_S);
        op_legal  = (bus.opcode == OP_R)   || (bus.opcode == OP_I)   || op_load  ||
                    op_store               || op_branch              ||
                    (bus.opcode == OP_LUI) || (bus.opcode == OP_JAL) ||
                    (bus.opcode == OP_JALR);
    end

    assign wait_inc = wait_q + 4'd1;

    always_comb begin
        state_d    = state_q;
        fault_d    = fault_q;
        wait_d     = wait_q;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        ram_we     = 1'b0;
        ir_we      = 1'b0;
        mdr_we     = 1'b0;
        rf_we      = 1'b0;
        pc_we      = 1'b0;
        pc_take    = 1'b0;
        instr_done = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                if (bus.imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                    wait_d  = '0;
                end else if (wait_inc == WAIT_MAX) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_inc;
                end
            end
            S_DECODE: begin
                if (!op_legal) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (op_branch) begin
                    pc_we      = 1'b1;
                    pc_take    = bus.branch_taken;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else if (op_load || op_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                ram_we   = op_store;
                if (bus.dmem_ready) begin
                    if (op_store) begin
                        pc_we      = 1'b1;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end else begin
                        mdr_we  = 1'b1;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we      = 1'b1;
                pc_we      = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: ;
        endcase
        // Reset cycle must never commit anything, even mid-instruction.
        if (cpu_rst) begin
            imem_req   = 1'b0;
            dmem_req   = 1'b0;
            ram_we     = 1'b0;
            ir_we      = 1'b0;
            mdr_we     = 1'b0;
            rf_we      = 1'b0;
            pc_we      = 1'b0;
            pc_take    = 1'b0;
            instr_done = 1'b0;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q <= S_FETCH;
            fault_q <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            wait_q  <= wait_d;
        end
    end

    assign bus.imem_req   = imem_req;
    assign bus.dmem_req   = dmem_req;
    assign bus.ram_we     = ram_we;
    assign bus.ir_we      = ir_we;
    assign bus.mdr_we     = mdr_we;
    assign bus.rf_we      = rf_we;
    assign bus.pc_we      = pc_we;
    assign bus.pc_take    = pc_take;
    assign bus.instr_done = instr_done;
    assign bus.state      = state_q;
    assign bus.fault      = fault_q;

`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] instret_cnt_q, instret_cnt_d;

    always_comb begin
        cycle_cnt_d   = cycle_cnt_q;
        instret_cnt_d = instret_cnt_q;
        if (state_q != S_HALT) cycle_cnt_d = cycle_cnt_q + 32'd1;
        if (instr_done)        instret_cnt_d = instret_cnt_q + 32'd1;
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign bus.cycle_cnt   = cycle_cnt_q;
    assign bus.instret_cnt = instret_cnt_q;
`else
    assign bus.cycle_cnt   = '0;
    assign bus.instret_cnt = '0;
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: each instruction's cycle-by-cycle expectation
// is derived from opcode class and injected wait counts, not from the FSM itself.
module tb_multicycle_ctrl;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
`ifdef MC_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk;
    logic cpu_rst;
    int   checks;
    int   errors;
    int   exp_cyc;
    int   exp_ret;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.IMEM_WAIT_MAX(15)) dut (
        .cpu_clk (clk),
        .cpu_rst (cpu_rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire any_strobe = bus.imem_req | bus.dmem_req | bus.ram_we | bus.ir_we | bus.mdr_we |
                      bus.rf_we | bus.pc_we | bus.pc_take | bus.instr_done;

    // One instruction, zero idle between calls; entered just after a clock edge.
    task automatic run_instr(input logic [6:0] op, input int iw, input int dw, input logic br);
        int   exp_st[$];
        int   nf, nd, done_at, ir_at, mdr_at, rf_n, ram_n, dreq_n, ireq_n, pcw_n, bad_at;
        logic take;
        bit   is_b, is_s, is_ld, mem, pair_bad, ramq_bad;
        is_b  = (op == OP_B);
        is_s  = (op == OP_S);
        is_ld = (op == OP_LOAD);
        mem   = is_s || is_ld;
        for (int i = 0; i <= iw; i++) exp_st.push_back(0);
        exp_st.push_back(1);
        exp_st.push_back(2);
        if (mem) for (int i = 0; i <= dw; i++) exp_st.push_back(3);
        if (!is_b && !is_s) exp_st.push_back(4);
        nf = 0; nd = 0; done_at = -1; ir_at = -1; mdr_at = -1; bad_at = -1;
        rf_n = 0; ram_n = 0; dreq_n = 0; ireq_n = 0; pcw_n = 0;
        take = 1'b0; pair_bad = 0; ramq_bad = 0;
        bus.branch_taken = br;
        for (int c = 0; c < 64 && done_at < 0; c++) begin
            @(negedge clk);
            bus.opcode     = (c <= iw) ? 7'($urandom) : op;
            bus.imem_ready = (nf >= iw);
            bus.dmem_ready = (nd >= dw);
            #1;
            if (bad_at < 0 && (c >= exp_st.size() || bus.state !== 3'(exp_st[c]))) bad_at = c;
            if (bus.pc_we !== bus.instr_done) pair_bad = 1;
            if (bus.ram_we && !bus.dmem_req) ramq_bad = 1;
            if (bus.imem_req) begin nf++; ireq_n++; end
            if (bus.dmem_req) begin nd++; dreq_n++; end
            if (bus.ir_we)  ir_at = c;
            if (bus.mdr_we) mdr_at = c;
            if (bus.rf_we)  rf_n++;
            if (bus.ram_we) ram_n++;
            if (bus.pc_we)  pcw_n++;
            if (bus.instr_done) begin done_at = c; take = bus.pc_take; end
            @(posedge clk);
            exp_cyc++;
        end
        exp_ret++;
        checks++; if (done_at != exp_st.size() - 1) begin errors++; $display("FAIL latency op=%b got=%0d exp=%0d", op, done_at + 1, exp_st.size()); end
        checks++; if (bad_at >= 0) begin errors++; $display("FAIL state_seq op=%b first bad cycle=%0d exp=%0d", op, bad_at, (bad_at < exp_st.size()) ? exp_st[bad_at] : -1); end
        checks++; if (pcw_n != 1) begin errors++; $display("FAIL pc_we_count op=%b got=%0d exp=1", op, pcw_n); end
        checks++; if (ir_at != iw) begin errors++; $display("FAIL ir_we_cycle op=%b got=%0d exp=%0d", op, ir_at, iw); end
        checks++; if (ireq_n != iw + 1) begin errors++; $display("FAIL imem_req_cycles op=%b got=%0d exp=%0d", op, ireq_n, iw + 1); end
        checks++; if (dreq_n != (mem ? dw + 1 : 0)) begin errors++; $display("FAIL dmem_req_cycles op=%b got=%0d exp=%0d", op, dreq_n, mem ? dw + 1 : 0); end
        checks++; if (ram_n != (is_s ? dw + 1 : 0)) begin errors++; $display("FAIL ram_we_cycles op=%b got=%0d exp=%0d", op, ram_n, is_s ? dw + 1 : 0); end
        checks++; if (mdr_at != (is_ld ? iw + 3 + dw : -1)) begin errors++; $display("FAIL mdr_we_cycle op=%b got=%0d exp=%0d", op, mdr_at, is_ld ? iw + 3 + dw : -1); end
        checks++; if (rf_n != ((is_b || is_s) ? 0 : 1)) begin errors++; $display("FAIL rf_we_count op=%b got=%0d exp=%0d", op, rf_n, (is_b || is_s) ? 0 : 1); end
        checks++; if (take !== (is_b & br)) begin errors++; $display("FAIL pc_take op=%b got=%b exp=%b", op, take, is_b & br); end
        checks++; if (pair_bad || ramq_bad) begin errors++; $display("FAIL strobe_pairing op=%b pc_we!=instr_done=%0d ram_we_wo_req=%0d exp=0,0", op, pair_bad, ramq_bad); end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            cpu_rst        = 1'b1;
            bus.imem_ready = 1'($urandom);
            bus.dmem_ready = 1'($urandom);
            bus.opcode     = 7'($urandom);
            #1;
            checks++; if (any_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobes got=%b exp=0", any_strobe); end
            @(posedge clk);
        end
        #1;
        cpu_rst = 1'b0;
        exp_cyc = 0;
        exp_ret = 0;
        checks++; if (bus.state !== 3'd0 || bus.fault !== 1'b0) begin errors++; $display("FAIL reset_state state=%0d fault=%b exp=0,0", bus.state, bus.fault); end
        checks++; if (bus.cycle_cnt !== 32'd0 || bus.instret_cnt !== 32'd0) begin errors++; $display("FAIL reset_counters cyc=%0d ret=%0d exp=0,0", bus.cycle_cnt, bus.instret_cnt); end
    endtask

    task automatic test_zero_wait_seq();
        test_reset();
        run_instr(OP_R, 0, 0, 1'b0);
        run_instr(OP_B, 0, 0, 1'b1);
        run_instr(OP_B, 0, 0, 1'b0);
        @(negedge clk); #1;
        checks++; if (bus.instret_cnt !== (PERF ? 32'd3 : 32'd0)) begin errors++; $display("FAIL instret_seq got=%0d exp=%0d", bus.instret_cnt, PERF ? 3 : 0); end
        checks++; if (bus.cycle_cnt !== (PERF ? 32'(exp_cyc) : 32'd0)) begin errors++; $display("FAIL cycle_seq got=%0d exp=%0d", bus.cycle_cnt, PERF ? exp_cyc : 0); end
        @(posedge clk);
        exp_cyc++;
    endtask

    task automatic test_load_wait();
        test_reset();
        run_instr(OP_LOAD, 0, 2, 1'b0);
    endtask

    task automatic test_store();
        test_reset();
        run_instr(OP_S, 0, 0, 1'b1);
    endtask

    task automatic test_random();
        logic [6:0] ops [8];
        ops = '{OP_R, OP_I, OP_LOAD, OP_S, OP_B, OP_LUI, OP_JAL, OP_JALR};
        test_reset();
        for (int n = 0; n < 24; n++)
            run_instr(ops[$urandom_range(7)], $urandom_range(3), $urandom_range(3), 1'($urandom));
        @(negedge clk); #1;
        checks++; if (bus.instret_cnt !== (PERF ? 32'(exp_ret) : 32'd0)) begin errors++; $display("FAIL instret_random got=%0d exp=%0d", bus.instret_cnt, PERF ? exp_ret : 0); end
        checks++; if (bus.cycle_cnt !== (PERF ? 32'(exp_cyc) : 32'd0)) begin errors++; $display("FAIL cycle_random got=%0d exp=%0d", bus.cycle_cnt, PERF ? exp_cyc : 0); end
        @(posedge clk);
    endtask

    task automatic test_illegal();
        int strobe_hits, halt_bad;
        test_reset();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            bus.opcode = 7'b0000000; bus.imem_ready = 1'b1; bus.dmem_ready = 1'b0;
            @(posedge clk);
            exp_cyc++;
        end
        strobe_hits = 0; halt_bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            bus.imem_ready = 1'($urandom); bus.dmem_ready = 1'($urandom);
            bus.branch_taken = 1'($urandom); bus.opcode = 7'($urandom);
            #1;
            if (any_strobe) strobe_hits++;
            if (bus.state !== 3'd5 || bus.fault !== 1'b1) halt_bad++;
            @(posedge clk);
        end
        #1;
        checks++; if (halt_bad != 0) begin errors++; $display("FAIL illegal_halt bad_cycles=%0d exp=0 state=%0d fault=%b", halt_bad, bus.state, bus.fault); end
        checks++; if (strobe_hits != 0) begin errors++; $display("FAIL illegal_strobes got=%0d exp=0", strobe_hits); end
        checks++; if (bus.cycle_cnt !== (PERF ? 32'(exp_cyc) : 32'd0)) begin errors++; $display("FAIL illegal_cycle_frozen got=%0d exp=%0d", bus.cycle_cnt, PERF ? exp_cyc : 0); end
    endtask

    task automatic test_imem_timeout();
        int not_fetch;
        test_reset();
        not_fetch = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            bus.imem_ready = 1'b0; bus.opcode = OP_R;
            #1;
            if (bus.state !== 3'd0 || bus.imem_req !== 1'b1) not_fetch++;
            @(posedge clk);
        end
        @(negedge clk); #1;
        checks++; if (not_fetch != 0) begin errors++; $display("FAIL timeout_fetch_cycles bad=%0d exp=0", not_fetch); end
        checks++; if (bus.state !== 3'd5 || bus.fault !== 1'b1 || bus.imem_req !== 1'b0) begin errors++; $display("FAIL timeout_halt state=%0d fault=%b req=%b exp=5,1,0", bus.state, bus.fault, bus.imem_req); end
        cpu_rst = 1'b1;
        @(posedge clk); #1;
        cpu_rst = 1'b0;
        checks++; if (bus.state !== 3'd0 || bus.fault !== 1'b0) begin errors++; $display("FAIL timeout_recover state=%0d fault=%b exp=0,0", bus.state, bus.fault); end
    endtask

    task automatic test_reset_mid_store();
        int pcw_n;
        test_reset();
        pcw_n = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            bus.opcode = OP_S; bus.imem_ready = 1'b1; bus.dmem_ready = 1'b0;
            #1;
            if (bus.pc_we) pcw_n++;
            if (c == 3) begin
                checks++; if (bus.dmem_req !== 1'b1 || bus.ram_we !== 1'b1) begin errors++; $display("FAIL mid_store_mem req=%b we=%b exp=1,1", bus.dmem_req, bus.ram_we); end
            end
            @(posedge clk);
        end
        @(negedge clk);
        cpu_rst = 1'b1;
        #1;
        if (bus.pc_we) pcw_n++;
        checks++; if (bus.dmem_req !== 1'b0 || bus.ram_we !== 1'b0 || bus.rf_we !== 1'b0) begin errors++; $display("FAIL mid_store_rst_strobes req=%b we=%b rf=%b exp=0,0,0", bus.dmem_req, bus.ram_we, bus.rf_we); end
        @(posedge clk); #1;
        cpu_rst = 1'b0;
        checks++; if (bus.state !== 3'd0 || bus.fault !== 1'b0) begin errors++; $display("FAIL mid_store_after state=%0d fault=%b exp=0,0", bus.state, bus.fault); end
        checks++; if (pcw_n != 0) begin errors++; $display("FAIL mid_store_pc_we got=%0d exp=0", pcw_n); end
    endtask

    task automatic test_counter_wrap();
        logic [31:0] seen [3];
        test_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus.imem_ready = 1'b0;
`ifdef MC_PERF_CNT_EN
            if (c == 0) begin
                force dut.cycle_cnt_q = 32'hFFFF_FFFE;
                #1;
                release dut.cycle_cnt_q;
            end
`endif
            #1;
            seen[c] = bus.cycle_cnt;
            @(posedge clk);
        end
        checks++; if (seen[0] !== (PERF ? 32'hFFFF_FFFE : 32'd0)) begin errors++; $display("FAIL wrap_preset got=%h exp=%h", seen[0], PERF ? 32'hFFFF_FFFE : 32'd0); end
        checks++; if (seen[1] !== (PERF ? 32'hFFFF_FFFF : 32'd0)) begin errors++; $display("FAIL wrap_max got=%h exp=%h", seen[1], PERF ? 32'hFFFF_FFFF : 32'd0); end
        checks++; if (seen[2] !== 32'd0) begin errors++; $display("FAIL wrap_zero got=%h exp=0", seen[2]); end
    endtask

    initial begin
        checks = 0; errors = 0; exp_cyc = 0; exp_ret = 0;
        cpu_rst = 1'b1;
        bus.opcode = '0; bus.branch_taken = 1'b0; bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
        test_reset();
        test_zero_wait_seq();
        test_load_wait();
        test_store();
        test_random();
        test_illegal();
        test_imem_timeout();
        test_reset_mid_store();
        test_counter_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
        $finish;
    end
endmodule
